sound_ram_arbiter: RTL and testbench

Arbiter and sequencer for the 64 KB sound RAM shared between the sound GLU (host-side RAM reads/writes) and the ES5503 DOC (oscillator sample fetch). Replaces the combinational address mux ahead of the single-port synchronous RAM with a request/acknowledge controller. DOC has priority, and an optional fairness guard bounds GLU wait time. Sits between `soundglu`, `es5503` and `syncram` inside the sound subsystem.

---
 rtl/sound_ram_arbiter_if.sv | 37 +++
 rtl/sound_ram_arbiter.sv | 143 ++++++++++++++
 tb/tb_sound_ram_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sound_ram_arbiter_if.sv
// Sound RAM arbiter bus bundle: DOC fetch, GLU access and RAM port.
// slave = arbiter side, master = clients plus RAM side.
interface sound_ram_arbiter_if;
    logic        doc_req;
    logic [15:0] doc_addr;
    logic [7:0]  doc_data;
    logic        doc_ack;
    logic        glu_req;
    logic        glu_wr;
    logic [15:0] glu_addr;
    logic [7:0]  glu_wdata;
    logic [7:0]  glu_rdata;
    logic        glu_ack;
    logic        glu_wait;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    modport slave (
        input  doc_req, doc_addr,
        input  glu_req, glu_wr, glu_addr, glu_wdata,
        input  ram_rdata,
        output doc_data, doc_ack,
        output glu_rdata, glu_ack, glu_wait,
        output ram_addr, ram_we, ram_wdata
    );

    modport master (
        output doc_req, doc_addr,
        output glu_req, glu_wr, glu_addr, glu_wdata,
        output ram_rdata,
        input  doc_data, doc_ack,
        input  glu_rdata, glu_ack, glu_wait,
        input  ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/sound_ram_arbiter.sv
// Sound RAM arbiter: DOC-priority IDLE/ACC/CAP access sequencer.
// Optional GLU fairness guard enabled by SOUND_ARB_FAIRNESS_EN.
module sound_ram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                CLK_14M,
    input  logic                reset_n,
    input  logic                clk_7M_en,
    sound_ram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        CAP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        gnt_glu_q, gnt_glu_d;
    logic        wr_q, wr_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_wdata_q, ram_wdata_d;
    logic [7:0]  doc_data_q, doc_data_d;
    logic [7:0]  glu_rdata_q, glu_rdata_d;

    logic slot;
    logic force_glu;
    logic take_glu;
    logic take_doc;

    assign slot     = (state_q == IDLE) && clk_7M_en;
    assign take_glu = slot && bus.glu_req && (!bus.doc_req || force_glu);
    assign take_doc = slot && bus.doc_req && !take_glu;

`ifdef SOUND_ARB_FAIRNESS_EN
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_q, starve_d;

    assign force_glu = bus.glu_req && (starve_q == LIMIT);

    always_comb begin
        starve_d = starve_q;
        if (take_glu) begin
            starve_d = '0;
        end else if (take_doc && bus.glu_req) begin
            starve_d = starve_q + SW'(1);
        end else if (state_q == IDLE && !bus.glu_req) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge CLK_14M or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_limit;

    assign unused_limit = ^STARVE_LIMIT;
    assign force_glu    = 1'b0;
`endif

    always_ff @(posedge CLK_14M or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            gnt_glu_q   <= 1'b0;
            wr_q        <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            doc_data_q  <= '0;
            glu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_glu_q   <= gnt_glu_d;
            wr_q        <= wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            doc_data_q  <= doc_data_d;
            glu_rdata_q <= glu_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (take_glu || take_doc) state_d = ACC;
            ACC:     state_d = CAP;
            CAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant latches the winner's request; CAP captures the read byte.
    always_comb begin
        gnt_glu_d   = gnt_glu_q;
        wr_d        = wr_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        doc_data_d  = doc_data_q;
        glu_rdata_d = glu_rdata_q;
        if (take_glu) begin
            gnt_glu_d   = 1'b1;
            wr_d        = bus.glu_wr;
            ram_addr_d  = bus.glu_addr;
            ram_wdata_d = bus.glu_wdata;
        end else if (take_doc) begin
            gnt_glu_d  = 1'b0;
            wr_d       = 1'b0;
            ram_addr_d = bus.doc_addr;
        end
        if (state_q == CAP) begin
            if (!gnt_glu_q) begin
                doc_data_d = bus.ram_rdata;
            end else if (!wr_q) begin
                glu_rdata_d = bus.ram_rdata;
            end
        end
    end

    always_comb begin
        bus.ram_addr  = ram_addr_q;
        bus.ram_wdata = ram_wdata_q;
        bus.ram_we    = (state_q == ACC) && gnt_glu_q && wr_q;
        bus.doc_ack   = (state_q == CAP) && !gnt_glu_q;
        bus.glu_ack   = (state_q == CAP) && gnt_glu_q;
        bus.doc_data  = doc_data_q;
        bus.glu_rdata = glu_rdata_q;
        if (bus.doc_ack) begin
            bus.doc_data = bus.ram_rdata;
        end
        if (bus.glu_ack && !wr_q) begin
            bus.glu_rdata = bus.ram_rdata;
        end
        bus.glu_wait = reset_n && bus.glu_req &&
                       ((state_q == IDLE) || !gnt_glu_q);
    end

endmodule

// File: tb/tb_sound_ram_arbiter.sv
// Directed bench for sound_ram_arbiter with a registered RAM model.
// Fairness checks follow SOUND_ARB_FAIRNESS_EN.
module tb_sound_ram_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;

    sound_ram_arbiter_if bus ();

    sound_ram_arbiter #(
        .STARVE_LIMIT (8)
    ) dut (
        .CLK_14M   (clk),
        .reset_n   (rst_n),
        .clk_7M_en (en),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];

    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic glu_op(input logic wr, input logic [15:0] a,
                          input logic [7:0] d, input logic [7:0] rd);
        bus.glu_req   = 1'b1;
        bus.glu_wr    = wr;
        bus.glu_addr  = a;
        bus.glu_wdata = d;
        en = 1'b1;
        tick();
        en = 1'b0;
        chk("glu_acc_addr", bus.ram_addr, a);
        chk("glu_acc_we", bus.ram_we, wr);
        chk("glu_acc_wait", bus.glu_wait, 0);
        if (wr) chk("glu_acc_wdata", bus.ram_wdata, d);
        tick();
        chk("glu_cap_ack", bus.glu_ack, 1);
        chk("glu_cap_we", bus.ram_we, 0);
        chk("glu_cap_docack", bus.doc_ack, 0);
        if (!wr) chk("glu_rdata", bus.glu_rdata, rd);
        bus.glu_req = 1'b0;
        tick();
        chk("glu_ack_low", bus.glu_ack, 0);
        if (!wr) chk("glu_rdata_hold", bus.glu_rdata, rd);
    endtask

    task automatic doc_op(input logic [15:0] a, input logic [7:0] rd,
                          input logic drop);
        bus.doc_req  = 1'b1;
        bus.doc_addr = a;
        en = 1'b1;
        tick();
        en = 1'b0;
        if (drop) bus.doc_req = 1'b0;
        chk("doc_acc_addr", bus.ram_addr, a);
        chk("doc_acc_we", bus.ram_we, 0);
        chk("doc_acc_ack", bus.doc_ack, 0);
        tick();
        chk("doc_cap_ack", bus.doc_ack, 1);
        chk("doc_cap_data", bus.doc_data, rd);
        chk("doc_cap_gluack", bus.glu_ack, 0);
        bus.doc_req = 1'b0;
        en = 1'b1;
        tick();
        chk("doc_ack_low", bus.doc_ack, 0);
        chk("doc_data_hold", bus.doc_data, rd);
        tick();
        en = 1'b0;
        chk("doc_no_reack", bus.doc_ack, 0);
    endtask

    int runs[$];
    int dcount = 0;
    int nglu   = 0;
    int ndoc   = 0;
    bit both   = 1'b0;

    initial begin
        bus.doc_req   = 1'b0;
        bus.doc_addr  = '0;
        bus.glu_req   = 1'b1;
        bus.glu_wr    = 1'b0;
        bus.glu_addr  = '0;
        bus.glu_wdata = '0;
        #2;
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_we", bus.ram_we, 0);
        chk("rst_wdata", bus.ram_wdata, 0);
        chk("rst_docdata", bus.doc_data, 0);
        chk("rst_glurdata", bus.glu_rdata, 0);
        chk("rst_docack", bus.doc_ack, 0);
        chk("rst_gluack", bus.glu_ack, 0);
        chk("rst_wait", bus.glu_wait, 0);
        bus.glu_req = 1'b0;
        #20 rst_n = 1'b1;
        tick();

        glu_op(1'b1, 16'h0100, 8'hA5, 8'h00);
        glu_op(1'b1, 16'h0200, 8'h3C, 8'h00);
        glu_op(1'b1, 16'hFFFF, 8'h5A, 8'h00);
        glu_op(1'b0, 16'hFFFF, 8'h00, 8'h5A);
        doc_op(16'h0100, 8'hA5, 1'b0);
        doc_op(16'h0200, 8'h3C, 1'b1);

        // Contention: DOC first, GLU waits until the next slot
        bus.doc_req  = 1'b1;
        bus.doc_addr = 16'h0200;
        bus.glu_req  = 1'b1;
        bus.glu_wr   = 1'b0;
        bus.glu_addr = 16'h0100;
        en = 1'b1;
        #1;
        chk("ct_wait_idle", bus.glu_wait, 1);
        tick();
        en = 1'b0;
        chk("ct_acc_addr", bus.ram_addr, 16'h0200);
        chk("ct_acc_wait", bus.glu_wait, 1);
        tick();
        chk("ct_doc_ack", bus.doc_ack, 1);
        chk("ct_doc_data", bus.doc_data, 8'h3C);
        chk("ct_cap_wait", bus.glu_wait, 1);
        bus.doc_req = 1'b0;
        tick();
        chk("ct_idle_wait", bus.glu_wait, 1);
        en = 1'b1;
        tick();
        en = 1'b0;
        chk("ct_glu_addr", bus.ram_addr, 16'h0100);
        chk("ct_glu_wait", bus.glu_wait, 0);
        tick();
        chk("ct_glu_ack", bus.glu_ack, 1);
        chk("ct_glu_rdata", bus.glu_rdata, 8'hA5);
        bus.glu_req = 1'b0;
        tick();

        // Sustained contention with alternating slots
        bus.doc_req  = 1'b1;
        bus.doc_addr = 16'h0100;
        bus.glu_req  = 1'b1;
        bus.glu_wr   = 1'b0;
        bus.glu_addr = 16'h0200;
        en = 1'b1;
        for (int i = 0; i < 120; i++) begin
            tick();
            en = ~en;
            if (bus.doc_ack && bus.glu_ack) both = 1'b1;
            if (bus.doc_ack) begin
                dcount++;
                ndoc++;
            end
            if (bus.glu_ack) begin
                nglu++;
                runs.push_back(dcount);
                dcount = 0;
                chk("fair_glu_rdata", bus.glu_rdata, 8'h3C);
            end
        end
        chk("ack_exclusive", both, 0);
`ifdef SOUND_ARB_FAIRNESS_EN
        chk("fair_nglu", nglu >= 2, 1);
        chk("fair_run0", runs.size() > 0 ? runs[0] : -1, 8);
        chk("fair_run1", runs.size() > 1 ? runs[1] : -1, 8);
`else
        chk("nofair_nglu", nglu, 0);
        chk("nofair_ndoc", ndoc > 20, 1);
`endif
        bus.doc_req = 1'b0;
        bus.glu_req = 1'b0;
        en = 1'b0;
        repeat (4) tick();

        // Reset in the middle of a GLU write
        glu_op(1'b1, 16'h1234, 8'h11, 8'h00);
        bus.glu_req   = 1'b1;
        bus.glu_wr    = 1'b1;
        bus.glu_addr  = 16'h1234;
        bus.glu_wdata = 8'h77;
        en = 1'b1;
        tick();
        en = 1'b0;
        chk("mr_acc_we", bus.ram_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_we", bus.ram_we, 0);
        chk("mr_addr", bus.ram_addr, 0);
        chk("mr_wdata", bus.ram_wdata, 0);
        chk("mr_glurdata", bus.glu_rdata, 0);
        chk("mr_docdata", bus.doc_data, 0);
        chk("mr_wait", bus.glu_wait, 0);
        bus.glu_req = 1'b0;
        tick();
        chk("mr_gluack0", bus.glu_ack, 0);
        tick();
        chk("mr_gluack1", bus.glu_ack, 0);
        chk("mr_docack", bus.doc_ack, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("mr_rel_we", bus.ram_we, 0);
        chk("mr_rel_ack", bus.glu_ack, 0);
        glu_op(1'b0, 16'h1234, 8'h00, 8'h11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
